dtree_node_datapath: RTL and testbench
======================================

# dtree_node_datapath

Arithmetic datapath that evaluates one decision-tree node hyperplane for a buffered spike feature vector. It sits beside the tree control FSM and consumes its per-cycle commands (`load_bias`, `add`, `mult`, `is_one`, `is_zero`, `coeff`, `bias`). It returns the branch decision on `child_direction`. It also owns the single-entry feature buffer fed by the upstream feature extractor, and raises `feat_valid` to the control FSM's `in_valid`.

## Interface
- `FEATURES`, 3, number of features per spike.
- `FEATURE_BIT_DEPTH`, 8, signed two's-complement feature width.
- `COEFF_BIT_DEPTH`, 4, signed two's-complement coefficient width.
- `BIAS_BIT_DEPTH`, 10, signed two's-complement bias width.
- `ACC_BIT_DEPTH`, 16, signed accumulator width; must be ≥ max(`BIAS_BIT_DEPTH`, `FEATURE_BIT_DEPTH`+`COEFF_BIT_DEPTH`).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream feature vector valid.
- `in_feature`  in  `FEATURES*FEATURE_BIT_DEPTH`  feature vector, feature 0 in the LSBs.
- `in_ready`  out  1  buffer can accept a vector.
- `feat_valid`  out  1  buffer holds a vector; drives control `in_valid`.
- `spike_done`  in  1  control `out_valid`; releases the buffer.
- `node_valid`  in  1  node evaluation cycle.
- `load_bias`, `add`, `mult`, `is_one`, `is_zero`  in  1 each  per-cycle control commands.
- `coeff`  in  `COEFF_BIT_DEPTH`  multiplier coefficient.
- `bias`  in  `BIAS_BIT_DEPTH`  node bias.
- `child_direction`  out  1  1 means right child (acc ≥ 0), 0 means left.
- `acc_out`  out  `ACC_BIT_DEPTH`  accumulator value, for debug and verification.
- `seq_error`  out  1  sticky command-sequence error.

## Operation
- **Buffer**
  - `in_ready = ~full | spike_done`.
  - On `in_valid & in_ready`: latch `in_feature` and set `full`.
  - On `spike_done` without a load: clear `full`.
  - Simultaneous `spike_done` and load: the new vector replaces the old one and `full` stays 1.
  - `feat_valid = full`.
- **Node evaluation.** Acts only when `node_valid & full`.
  - Cycle with `load_bias=1`: `acc <= sext(bias)`, pointer `p <= 0`. All other commands are ignored in this cycle.
  - Later cycles: take `x = feature[p]`.
  - The term is selected by priority:
    - `is_zero` gives 0;
    - else `is_one` gives `sext(x)`;
    - else `mult` gives `sext(x*coeff)`, a full signed product of `FEATURE_BIT_DEPTH+COEFF_BIT_DEPTH` bits;
    - else 0.
  - If `add`: `acc <= sat(acc + term)`. `p` increments every non-bias `node_valid` cycle, whether or not `add` is set.
- **Saturation.** Results above 2^(ACC-1)-1 clamp to that maximum; results below -2^(ACC-1) clamp to that minimum. Wrap-around is never allowed.
- **Direction.** `child_direction = full & ~acc[ACC_BIT_DEPTH-1]`. It is combinational from registered state and is stable during the control's decide cycle.
- **Errors.** `seq_error` is set, and held until reset, in either case:
  - `node_valid` arrives with `full=0`; the command is ignored and `acc` is unchanged.
  - A non-bias cycle arrives with `p == FEATURES`; `acc` and `p` are held and no term is added.
- **Reset outputs.**
  - `in_ready=1`, `feat_valid=0`, `child_direction=0`, `acc_out=0`, `seq_error=0`.
  - Internal state is cleared: `p=0`, buffer contents 0.
- **Reset mid-node.** The partial sum is discarded and the buffer is emptied. A vector presented during a `reset` cycle is not captured.

## Timing
- A captured vector is visible on `feat_valid` one cycle after the handshake.
- One node takes `FEATURES+1` `node_valid` cycles: 1 bias cycle plus `FEATURES` term cycles.
- `acc` updates at the clock edge ending each cycle. `child_direction` is valid in the cycle after the last term cycle and holds until the next `load_bias`.
- Buffer release: with `spike_done` in cycle t, `in_ready` is already 1 in cycle t. A new vector can therefore be loaded in cycle t, giving zero bubble cycles.
- There is no internal pipeline: multiplier and adder are single-cycle and combinational between registers.

## Structure
- Package `dtree_pkg`:
  - default width constants shared with the control FSM: `FEATURES`, `COEFF_BIT_DEPTH`, `BIAS_BIT_DEPTH`;
  - a saturating-add function;
  - a sign-extend helper.
- One sub-module `sat_mac`: term select, signed multiply and saturating accumulate register. The top level holds the buffer, pointer and error logic.

## Test plan
Vectors use features {f0,f1,f2}, `FEATURES=3` and `ACC_BIT_DEPTH=16` unless stated.
- **Basic node.** Features {10,-5,3}, bias -20; terms: f0 `is_one`, f1 `mult` with coeff 2, f2 `is_zero`. Required: `acc_out` goes -20 → -10 → -20 → -20, and `child_direction=0`.
- **Positive branch.** Same features, bias 4; f0 `mult` with coeff -1, f1 `mult` with coeff -3, f2 `is_one`. Required: acc = 4 - 10 + 15 + 3 = 12, `child_direction=1`.
- **Saturation.** With `ACC_BIT_DEPTH=10`: bias 500, f0=127 `is_one`. Required: `acc_out`=511, not -397. Then bias -512, f0=-128 `is_one`: required `acc_out`=-512.
- **Handshake.**
  - `in_valid` while full and no `spike_done`: `in_ready=0`, buffer unchanged.
  - `spike_done` and `in_valid` in the same cycle: the new vector is captured and `feat_valid` stays 1.
- **Errors.**
  - `node_valid` with the buffer empty: `seq_error=1`, `acc` unchanged.
  - A 4th term cycle: `seq_error=1`, `acc` held.
- **Reset mid-node.** Assert `reset` after the bias cycle with bias 100. Required next cycle: `acc_out=0`, `feat_valid=0`, `in_ready=1`, `child_direction=0`, `seq_error=0`.

Source files
------------

// File: rtl/dtree_pkg.sv
// Widths shared with the tree control FSM and arithmetic helpers for the node datapath.
package dtree_pkg;
  localparam int FEATURES        = 3;
  localparam int COEFF_BIT_DEPTH = 4;
  localparam int BIAS_BIT_DEPTH  = 10;

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
    logic signed [63:0] r;
    r = $signed(v << (64 - w));
    return r >>> (64 - w);
  endfunction

  // Add two small signed values and clamp the result to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s, mx, mn;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
  endfunction
endpackage

// File: rtl/dtree_node_datapath_sat_mac.sv
// Term select, signed multiply and saturating accumulator register for one node.
module dtree_node_datapath_sat_mac
  import dtree_pkg::*;
#(
  parameter int FEATURE_BIT_DEPTH = 8,
  parameter int COEFF_BIT_DEPTH   = 4,
  parameter int BIAS_BIT_DEPTH    = 10,
  parameter int ACC_BIT_DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_load,
  input  logic                         i_add,
  input  logic                         i_is_zero,
  input  logic                         i_is_one,
  input  logic                         i_mult,
  input  logic [FEATURE_BIT_DEPTH-1:0] i_x,
  input  logic [COEFF_BIT_DEPTH-1:0]   i_coeff,
  input  logic [BIAS_BIT_DEPTH-1:0]    i_bias,
  output logic [ACC_BIT_DEPTH-1:0]     o_acc
);
  localparam int PW = FEATURE_BIT_DEPTH + COEFF_BIT_DEPTH;

  logic signed [PW-1:0] w_xe, w_ce, w_prod;
  logic signed [63:0]   w_term, w_sum, w_bias;
  logic [ACC_BIT_DEPTH-1:0] r_acc;

  assign w_xe   = {{COEFF_BIT_DEPTH{i_x[FEATURE_BIT_DEPTH-1]}}, i_x};
  assign w_ce   = {{FEATURE_BIT_DEPTH{i_coeff[COEFF_BIT_DEPTH-1]}}, i_coeff};
  assign w_prod = w_xe * w_ce;

  always_comb begin
    w_term = '0;
    if (i_is_zero)     w_term = '0;
    else if (i_is_one) w_term = sext(64'(i_x), FEATURE_BIT_DEPTH);
    else if (i_mult)   w_term = sext(64'(w_prod), PW);
  end

  // Sum is formed at 64 bits so the clamp sees the true result, never a wrapped one.
  assign w_sum  = sat_add(sext(64'(r_acc), ACC_BIT_DEPTH), w_term, ACC_BIT_DEPTH);
  assign w_bias = sext(64'(i_bias), BIAS_BIT_DEPTH);

  always_ff @(posedge clk) begin
    if (reset)       r_acc <= '0;
    else if (i_load) r_acc <= w_bias[ACC_BIT_DEPTH-1:0];
    else if (i_add)  r_acc <= w_sum[ACC_BIT_DEPTH-1:0];
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/dtree_node_datapath.sv
// Decision-tree node datapath: single-entry feature buffer, term pointer,
// sequence-error flag and the saturating MAC that yields the branch direction.
module dtree_node_datapath
  import dtree_pkg::*;
#(
  parameter int FEATURES          = dtree_pkg::FEATURES,
  parameter int FEATURE_BIT_DEPTH = 8,
  parameter int COEFF_BIT_DEPTH   = dtree_pkg::COEFF_BIT_DEPTH,
  parameter int BIAS_BIT_DEPTH    = dtree_pkg::BIAS_BIT_DEPTH,
  parameter int ACC_BIT_DEPTH     = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_in_valid,
  input  logic [FEATURES*FEATURE_BIT_DEPTH-1:0] i_in_feature,
  output logic                                  o_in_ready,
  output logic                                  o_feat_valid,
  input  logic                                  i_spike_done,
  input  logic                                  i_node_valid,
  input  logic                                  i_load_bias,
  input  logic                                  i_add,
  input  logic                                  i_mult,
  input  logic                                  i_is_one,
  input  logic                                  i_is_zero,
  input  logic [COEFF_BIT_DEPTH-1:0]            i_coeff,
  input  logic [BIAS_BIT_DEPTH-1:0]             i_bias,
  output logic                                  o_child_direction,
  output logic [ACC_BIT_DEPTH-1:0]              o_acc_out,
  output logic                                  o_seq_error
);
  localparam int PTR_W = $clog2(FEATURES + 1);

  logic [FEATURES-1:0][FEATURE_BIT_DEPTH-1:0] r_buf;
  logic                                       r_full;
  logic [PTR_W-1:0]                           r_p;
  logic                                       r_err;
  logic [FEATURE_BIT_DEPTH-1:0]               w_x;
  logic w_load, w_act, w_term_cyc, w_ovr, w_step;

  assign o_in_ready   = ~r_full | i_spike_done;
  assign w_load       = i_in_valid & o_in_ready;
  assign o_feat_valid = r_full;

  // Release and reload in the same cycle keep the buffer full with the new vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
      r_buf  <= '0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_buf  <= i_in_feature;
    end else if (i_spike_done) begin
      r_full <= 1'b0;
    end
  end

  assign w_act      = i_node_valid & r_full;
  assign w_term_cyc = w_act & ~i_load_bias;
  assign w_ovr      = w_term_cyc & (r_p == PTR_W'(FEATURES));
  assign w_step     = w_term_cyc & ~w_ovr;

  always_ff @(posedge clk) begin
    if (reset)                     r_p <= '0;
    else if (w_act & i_load_bias)  r_p <= '0;
    else if (w_step)               r_p <= r_p + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)                                  r_err <= 1'b0;
    else if ((i_node_valid & ~r_full) | w_ovr)  r_err <= 1'b1;
  end

  always_comb begin
    w_x = '0;
    for (int i = 0; i < FEATURES; i++)
      if (r_p == PTR_W'(i)) w_x = r_buf[i];
  end

  dtree_node_datapath_sat_mac #(
    .FEATURE_BIT_DEPTH(FEATURE_BIT_DEPTH),
    .COEFF_BIT_DEPTH  (COEFF_BIT_DEPTH),
    .BIAS_BIT_DEPTH   (BIAS_BIT_DEPTH),
    .ACC_BIT_DEPTH    (ACC_BIT_DEPTH)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_act & i_load_bias),
    .i_add    (w_step & i_add),
    .i_is_zero(i_is_zero),
    .i_is_one (i_is_one),
    .i_mult   (i_mult),
    .i_x      (w_x),
    .i_coeff  (i_coeff),
    .i_bias   (i_bias),
    .o_acc    (o_acc_out)
  );

  assign o_child_direction = r_full & ~o_acc_out[ACC_BIT_DEPTH-1];
  assign o_seq_error       = r_err;
endmodule

// File: tb/tb_dtree_node_datapath.sv
// Directed bench for dtree_node_datapath: a 16-bit and a 10-bit accumulator
// instance share one stimulus stream.
module tb_dtree_node_datapath;
  logic        clk = 1'b0;
  logic        reset, in_valid, spike_done, node_valid;
  logic        load_bias, add, mult, is_one, is_zero;
  logic [23:0] in_feature;
  logic [3:0]  coeff;
  logic [9:0]  bias;

  logic        rdy16, fv16, dir16, err16;
  logic [15:0] acc16;
  logic        rdy10, fv10, dir10, err10;
  logic [9:0]  acc10;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dtree_node_datapath #(.ACC_BIT_DEPTH(16)) u16 (
    .clk(clk), .reset(reset), .i_in_valid(in_valid), .i_in_feature(in_feature),
    .o_in_ready(rdy16), .o_feat_valid(fv16), .i_spike_done(spike_done),
    .i_node_valid(node_valid), .i_load_bias(load_bias), .i_add(add), .i_mult(mult),
    .i_is_one(is_one), .i_is_zero(is_zero), .i_coeff(coeff), .i_bias(bias),
    .o_child_direction(dir16), .o_acc_out(acc16), .o_seq_error(err16));

  dtree_node_datapath #(.ACC_BIT_DEPTH(10)) u10 (
    .clk(clk), .reset(reset), .i_in_valid(in_valid), .i_in_feature(in_feature),
    .o_in_ready(rdy10), .o_feat_valid(fv10), .i_spike_done(spike_done),
    .i_node_valid(node_valid), .i_load_bias(load_bias), .i_add(add), .i_mult(mult),
    .i_is_one(is_one), .i_is_zero(is_zero), .i_coeff(coeff), .i_bias(bias),
    .o_child_direction(dir10), .o_acc_out(acc10), .o_seq_error(err10));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; spike_done = 0; node_valid = 0; load_bias = 0; add = 0;
    mult = 0; is_one = 0; is_zero = 0; coeff = '0; bias = '0;
  endtask

  task automatic do_reset();
    reset = 1; cyc(); reset = 0;
  endtask

  task automatic load_vec(input logic [7:0] f0, f1, f2);
    in_valid = 1; in_feature = {f2, f1, f0}; cyc(); in_valid = 0;
  endtask

  task automatic release_buf();
    spike_done = 1; cyc(); spike_done = 0;
  endtask

  task automatic cmd(input logic lb, a, m, one, zero, input logic [3:0] c, input logic [9:0] b);
    node_valid = 1; load_bias = lb; add = a; mult = m; is_one = one; is_zero = zero;
    coeff = c; bias = b;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    in_valid = 1; in_feature = 24'h030201; reset = 1;
    cyc();
    reset = 0; in_valid = 0;
    total++; if (rdy16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", rdy16); end
    total++; if (fv16 !== 1'b0) begin bad++; $display("FAIL reset_feat_valid got=%b exp=0", fv16); end
    total++; if (dir16 !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b exp=0", dir16); end
    total++; if (acc16 !== 16'h0) begin bad++; $display("FAIL reset_acc got=%h exp=0000", acc16); end
    total++; if (err16 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err16); end
  endtask

  task automatic test_basic();
    load_vec(8'd10, 8'hFB, 8'd3);
    total++; if (fv16 !== 1'b1) begin bad++; $display("FAIL basic_feat_valid got=%b exp=1", fv16); end
    cmd(1, 0, 0, 0, 0, 4'd0, 10'h3EC);               // bias -20
    total++; if (acc16 !== 16'hFFEC) begin bad++; $display("FAIL basic_bias got=%h exp=ffec", acc16); end
    cmd(0, 1, 0, 1, 0, 4'd0, 10'd0);                 // +10
    total++; if (acc16 !== 16'hFFF6) begin bad++; $display("FAIL basic_t0 got=%h exp=fff6", acc16); end
    cmd(0, 1, 1, 0, 0, 4'd2, 10'd0);                 // -5*2
    total++; if (acc16 !== 16'hFFEC) begin bad++; $display("FAIL basic_t1 got=%h exp=ffec", acc16); end
    cmd(0, 1, 0, 0, 1, 4'd0, 10'd0);                 // zero
    total++; if (acc16 !== 16'hFFEC) begin bad++; $display("FAIL basic_t2 got=%h exp=ffec", acc16); end
    total++; if (dir16 !== 1'b0) begin bad++; $display("FAIL basic_dir got=%b exp=0", dir16); end
  endtask

  task automatic test_positive();
    cmd(1, 0, 0, 0, 0, 4'd0, 10'd4);
    cmd(0, 1, 1, 0, 0, 4'hF, 10'd0);                 // 10*-1
    total++; if (acc16 !== 16'hFFFA) begin bad++; $display("FAIL pos_t0 got=%h exp=fffa", acc16); end
    cmd(0, 1, 1, 0, 0, 4'hD, 10'd0);                 // -5*-3
    total++; if (acc16 !== 16'd9) begin bad++; $display("FAIL pos_t1 got=%h exp=0009", acc16); end
    cmd(0, 1, 0, 1, 0, 4'd0, 10'd0);
    total++; if (acc16 !== 16'd12) begin bad++; $display("FAIL pos_t2 got=%h exp=000c", acc16); end
    total++; if (dir16 !== 1'b1) begin bad++; $display("FAIL pos_dir got=%b exp=1", dir16); end
    release_buf();
    total++; if (fv16 !== 1'b0) begin bad++; $display("FAIL release_feat_valid got=%b exp=0", fv16); end
  endtask

  task automatic test_saturation();
    load_vec(8'd127, 8'd0, 8'd0);
    cmd(1, 0, 0, 0, 0, 4'd0, 10'd500);
    cmd(0, 1, 0, 1, 0, 4'd0, 10'd0);
    total++; if (acc10 !== 10'h1FF) begin bad++; $display("FAIL sat_pos got=%h exp=1ff", acc10); end
    total++; if (acc16 !== 16'd627) begin bad++; $display("FAIL sat_pos_wide got=%h exp=0273", acc16); end
    release_buf();
    load_vec(8'h80, 8'd0, 8'd0);
    cmd(1, 0, 0, 0, 0, 4'd0, 10'h200);               // bias -512
    cmd(0, 1, 0, 1, 0, 4'd0, 10'd0);                 // -128
    total++; if (acc10 !== 10'h200) begin bad++; $display("FAIL sat_neg got=%h exp=200", acc10); end
  endtask

  task automatic test_handshake();
    in_valid = 1; in_feature = {8'd3, 8'd2, 8'd1};
    #1;
    total++; if (rdy16 !== 1'b0) begin bad++; $display("FAIL hs_full_ready got=%b exp=0", rdy16); end
    cyc(); in_valid = 0;
    cmd(1, 0, 0, 0, 0, 4'd0, 10'd0);
    cmd(0, 1, 0, 1, 0, 4'd0, 10'd0);
    total++; if (acc16 !== 16'hFF80) begin bad++; $display("FAIL hs_buf_kept got=%h exp=ff80", acc16); end
    in_valid = 1; spike_done = 1; in_feature = {8'd9, 8'd8, 8'd7};
    #1;
    total++; if (rdy16 !== 1'b1) begin bad++; $display("FAIL hs_swap_ready got=%b exp=1", rdy16); end
    cyc(); in_valid = 0; spike_done = 0;
    total++; if (fv16 !== 1'b1) begin bad++; $display("FAIL hs_swap_valid got=%b exp=1", fv16); end
    cmd(1, 0, 0, 0, 0, 4'd0, 10'd0);
    cmd(0, 1, 0, 1, 0, 4'd0, 10'd0);
    total++; if (acc16 !== 16'd7) begin bad++; $display("FAIL hs_swap_data got=%h exp=0007", acc16); end
  endtask

  task automatic test_errors();
    release_buf();
    total++; if (err16 !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", err16); end
    cmd(1, 0, 0, 0, 0, 4'd0, 10'd55);
    total++; if (err16 !== 1'b1) begin bad++; $display("FAIL err_empty got=%b exp=1", err16); end
    total++; if (acc16 !== 16'd7) begin bad++; $display("FAIL err_empty_acc got=%h exp=0007", acc16); end
    do_reset();
    load_vec(8'd7, 8'd8, 8'd9);
    cmd(1, 0, 0, 0, 0, 4'd0, 10'd0);
    for (int i = 0; i < 3; i++) cmd(0, 1, 0, 1, 0, 4'd0, 10'd0);
    total++; if (acc16 !== 16'd24) begin bad++; $display("FAIL err_sum got=%h exp=0018", acc16); end
    total++; if (err16 !== 1'b0) begin bad++; $display("FAIL err_clean got=%b exp=0", err16); end
    cmd(0, 1, 0, 1, 0, 4'd0, 10'd0);
    total++; if (err16 !== 1'b1) begin bad++; $display("FAIL err_overrun got=%b exp=1", err16); end
    total++; if (acc16 !== 16'd24) begin bad++; $display("FAIL err_overrun_acc got=%h exp=0018", acc16); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_vec(8'd1, 8'd2, 8'd3);
    cmd(1, 0, 0, 0, 0, 4'd0, 10'd100);
    total++; if (acc16 !== 16'd100) begin bad++; $display("FAIL mid_bias got=%h exp=0064", acc16); end
    node_valid = 1; add = 1; is_one = 1; reset = 1;
    cyc();
    reset = 0; idle();
    total++; if (acc16 !== 16'h0) begin bad++; $display("FAIL mid_acc got=%h exp=0000", acc16); end
    total++; if (fv16 !== 1'b0) begin bad++; $display("FAIL mid_feat_valid got=%b exp=0", fv16); end
    total++; if (rdy16 !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", rdy16); end
    total++; if (dir16 !== 1'b0) begin bad++; $display("FAIL mid_dir got=%b exp=0", dir16); end
    total++; if (err16 !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", err16); end
  endtask

  initial begin
    idle(); reset = 1; in_feature = '0;
    cyc(); cyc();
    test_reset();
    test_basic();
    test_positive();
    test_saturation();
    test_handshake();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
